// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants for the register file / scoreboard slice.
//   DEF_* are the default build parameters; modules take their own
//   parameters that default to these values.
//   CNT_MAX  - saturation value of a default-width pending counter.
//   ZERO_REG - address of the hardwired-zero register.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_CNT_W    = 2;

  localparam int CNT_MAX      = (1 << DEF_CNT_W) - 1;
  localparam int ZERO_REG     = 0;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if
//   Bundles the write-back, read and reserve ports of the register file.
//   master : pipeline side (decode / issue / write-back) driving requests
//   slave  : register file side returning data, busy and ready
//
//   Reserve handshake: rsv_en is a request qualified by rsv_ready. A
//   reservation takes effect on the rising edge only when rsv_en=1 and
//   rsv_ready=1 in the same cycle; rsv_en must not be raised while
//   rsv_ready=0 (such a request is ignored). Write-back and reads have no
//   back-pressure: wr_en is always accepted, reads are combinational.
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = DEF_NUM_RD
);

  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_busy;
  logic                       rsv_en;
  logic [ADDR_W-1:0]          rsv_addr;
  logic                       rsv_ready;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    input  rd_data, rd_busy, rsv_ready
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    output rd_data, rd_busy, rsv_ready
  );

endinterface

// File: rtl/rf_pending_ctr.sv
// rf_pending_ctr
//   Saturating up/down count of outstanding writers for one register.
//   clk     - clock
//   clear   - synchronous clear (register-file reset)
//   inc     - one more writer reserved this cycle
//   dec     - one writer retired this cycle
//   count   - current count
//   nonzero - count != 0
//   at_max  - count is all ones
//   inc at max and dec at zero are dropped so the count never wraps.
module rf_pending_ctr #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             at_max
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (dec && nonzero) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign count   = cnt_q;
  assign nonzero = |cnt_q;
  assign at_max  = &cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   General-purpose register file with per-register pending-write
//   scoreboard for hazard detection at decode.
//   clk   - clock, all state on rising edge
//   reset - synchronous active-high; clears data and all pending counts
//   bus   - slave side of regfile_scoreboard_if:
//             wr_en/wr_addr/wr_data  write-back port (same-cycle bypass)
//             rd_addr -> rd_data     NUM_RD combinational read ports
//             rd_busy                register on port p has a pending writer
//             rsv_en/rsv_addr        issue reserves a destination
//             rsv_ready              reservation of rsv_addr accepted now
//   Register 0 reads as zero, is never written and is never tracked.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_scoreboard_if.slave   bus
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt    [NUM_REGS];
  logic [NUM_REGS-1:0] cnt_nz;
  logic [NUM_REGS-1:0] cnt_max;
  logic [NUM_REGS-1:0] drains;   // write-back retiring the last pending writer
  logic                wr_live;
  logic                rsv_ready;
  logic                rsv_acc;

  assign wr_live = bus.wr_en && (bus.wr_addr != ZERO_ADDR);

  // A saturated register may still accept a reservation when a write-back
  // to it lands in the same cycle: the count then stays at max.
  assign rsv_ready     = !cnt_max[bus.rsv_addr] ||
                         (bus.wr_en && (bus.wr_addr == bus.rsv_addr));
  assign rsv_acc       = bus.rsv_en && rsv_ready;
  assign bus.rsv_ready = rsv_ready;

  // ---------------------------------------------------------------- data
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_live) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // ----------------------------------------------------------- scoreboard
  assign cnt[0]     = '0;
  assign cnt_nz[0]  = 1'b0;
  assign cnt_max[0] = 1'b0;
  assign drains[0]  = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_ctr
    logic wb_hit;
    logic rsv_hit;
    logic inc;
    logic dec;

    assign wb_hit  = bus.wr_en && (bus.wr_addr == ADDR_W'(r));
    assign rsv_hit = rsv_acc && (bus.rsv_addr == ADDR_W'(r));
    // Reserve and write-back together cancel: one writer in, one out.
    assign inc     = rsv_hit && !wb_hit;
    assign dec     = wb_hit && !rsv_hit;
    assign drains[r] = dec && (cnt[r] == CNT_ONE);

    rf_pending_ctr #(
      .CNT_W (CNT_W)
    ) u_ctr (
      .clk     (clk),
      .clear   (reset),
      .inc     (inc),
      .dec     (dec),
      .count   (cnt[r]),
      .nonzero (cnt_nz[r]),
      .at_max  (cnt_max[r])
    );
  end

  // ----------------------------------------------------------- read ports
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] rd_a;
    logic              bypass;

    assign rd_a   = bus.rd_addr[p*ADDR_W +: ADDR_W];
    assign bypass = wr_live && (bus.wr_addr == rd_a);

    assign bus.rd_data[p*DATA_W +: DATA_W] =
      (rd_a == ZERO_ADDR) ? '0 :
      bypass              ? bus.wr_data :
                            regs_q[rd_a];

    // The final write-back is bypassed into rd_data, so the reader need
    // not stall in the cycle it arrives.
    assign bus.rd_busy[p] = cnt_nz[rd_a] && !drains[rd_a];
  end

endmodule
